// File: rtl/image_scanner_pkg.sv
// ---------------------------------------------------------------------------
// image_scanner_pkg
//   Definitions shared by the image scanner, its RAM bus interface and the
//   RAM loader: the image entry geometry, the scanner state encoding and a
//   small address helper.
// ---------------------------------------------------------------------------
package image_scanner_pkg;

  localparam int RAM_WIDTH     = 8;
  localparam int RAM_ADDR_BITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_SHOW = 2'd3
  } scan_state_e;

  // Next image address; the natural overflow of the adder gives the
  // last -> 0 wrap because the depth is a power of two.
  function automatic logic [RAM_ADDR_BITS-1:0] next_addr(
    input logic [RAM_ADDR_BITS-1:0] addr
  );
    return addr + RAM_ADDR_BITS'(1);
  endfunction

endpackage

// File: rtl/image_scanner_if.sv
// ---------------------------------------------------------------------------
// image_scanner_if
//   Read-only bus between the image scanner and the image RAM.
//   ram_en   : read strobe from the scanner
//   ram_addr : read address from the scanner
//   ram_do   : read data from the RAM, valid one cycle after ram_en
//   master modport = scanner side, slave modport = RAM side.
//   There is deliberately no write path on this bus.
// ---------------------------------------------------------------------------
interface image_scanner_if;
  import image_scanner_pkg::*;

  logic                     ram_en;
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic [RAM_WIDTH-1:0]     ram_do;

  modport master (
    output ram_en,
    output ram_addr,
    input  ram_do
  );

  modport slave (
    input  ram_en,
    input  ram_addr,
    output ram_do
  );

endinterface

// File: rtl/image_scanner_dwell_timer.sv
// ---------------------------------------------------------------------------
// image_scanner_dwell_timer
//   Loadable down-counter that sets how long one image entry stays on display.
//   clk        : system clock
//   reset      : synchronous, active-high; clears the count to 0
//   load       : load load_value this cycle (takes priority over dec)
//   load_value : value to load
//   dec        : decrement by one; holds at zero
//   zero       : count is currently zero
// ---------------------------------------------------------------------------
module image_scanner_dwell_timer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && !zero) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/image_scanner.sv
// ---------------------------------------------------------------------------
// image_scanner
//   Walks the 8-entry image RAM one entry at a time and holds each entry on
//   the display outputs for DWELL_CYCLES cycles so a person can read it.
//   Either free-runs with wrap-around while run is high, or shows exactly
//   one entry per step pulse that arrives while idle.
//
//   clk        : system clock, all logic on posedge
//   reset      : synchronous, active-high
//   run        : level, 1 = scan continuously
//   step       : 1-cycle pulse, scan one entry (honoured only when idle)
//   ram        : read-only RAM bus (ram_en, ram_addr out; ram_do in)
//   disp_addr  : address of the entry being shown
//   disp_data  : entry being shown
//   disp_valid : 1 once any entry has been captured, until reset
//   frame_done : 1-cycle pulse when the scan address wraps last -> 0
//
//   Per entry: READ (strobe RAM) -> WAIT (RAM data valid, capture it)
//   -> SHOW (DWELL_CYCLES cycles), giving DWELL_CYCLES+2 cycles per entry.
// ---------------------------------------------------------------------------
module image_scanner
  import image_scanner_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000000,
  parameter int DWELL_BITS   = 26
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     step,
  image_scanner_if.master          ram,
  output logic [RAM_ADDR_BITS-1:0] disp_addr,
  output logic [RAM_WIDTH-1:0]     disp_data,
  output logic                     disp_valid,
  output logic                     frame_done
);

  // SHOW counts from DWELL_CYCLES-1 down to 0 inclusive, so it lasts
  // exactly DWELL_CYCLES cycles (one cycle when DWELL_CYCLES is 1).
  localparam logic [DWELL_BITS-1:0] DWELL_LOAD = DWELL_BITS'(DWELL_CYCLES - 1);

  scan_state_e              state_q,      state_d;
  logic [RAM_ADDR_BITS-1:0] addr_q,       addr_d;
  logic [RAM_ADDR_BITS-1:0] disp_addr_q,  disp_addr_d;
  logic [RAM_WIDTH-1:0]     disp_data_q,  disp_data_d;
  logic                     disp_valid_q, disp_valid_d;
  logic                     frame_done_q, frame_done_d;

  logic dwell_load;
  logic dwell_dec;
  logic dwell_zero;

  image_scanner_dwell_timer #(
    .WIDTH (DWELL_BITS)
  ) u_dwell_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (dwell_load),
    .load_value (DWELL_LOAD),
    .dec        (dwell_dec),
    .zero       (dwell_zero)
  );

  // The read strobe is decoded from state; the address is the registered
  // scan pointer, which only moves at the end of SHOW.
  assign ram.ram_en   = (state_q == ST_READ);
  assign ram.ram_addr = addr_q;

  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign frame_done = frame_done_q;

  // Next-state and datapath decode. A step pulse seen outside IDLE falls
  // through every other branch and is therefore dropped, not queued.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    frame_done_d = 1'b0;
    dwell_load   = 1'b0;
    dwell_dec    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run || step) begin
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        disp_data_d  = ram.ram_do;
        disp_addr_d  = addr_q;
        disp_valid_d = 1'b1;
        dwell_load   = 1'b1;
        state_d      = ST_SHOW;
      end

      ST_SHOW: begin
        if (dwell_zero) begin
          addr_d       = next_addr(addr_q);
          frame_done_d = (addr_q == '1);
          state_d      = run ? ST_READ : ST_IDLE;
        end else begin
          dwell_dec = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides everything, including a
  // RAM read that is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_image_scanner.sv
// ---------------------------------------------------------------------------
// tb_image_scanner
//   Drives image_scanner against a 1-cycle-read RAM holding 8'h10+i and a
//   reference model that tracks each entry as a cycle index into its
//   DWELL+2 cycle slot. Directed steps first, then a randomized run.
// ---------------------------------------------------------------------------
module tb_image_scanner;
  import image_scanner_pkg::*;

  localparam int DWELL      = 4;
  localparam int DWELL_BITS = 3;
  localparam int DEPTH      = 8;

  logic clk = 1'b0;
  logic reset;
  logic run;
  logic step;
  logic [RAM_ADDR_BITS-1:0] disp_addr;
  logic [RAM_WIDTH-1:0]     disp_data;
  logic                     disp_valid;
  logic                     frame_done;

  image_scanner_if ram_bus ();

  image_scanner #(
    .DWELL_CYCLES (DWELL),
    .DWELL_BITS   (DWELL_BITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .ram        (ram_bus),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Image RAM with synchronous read.
  logic [RAM_WIDTH-1:0] image [DEPTH];

  always @(posedge clk) begin
    if (ram_bus.ram_en) begin
      ram_bus.ram_do <= image[ram_bus.ram_addr];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: an entry in progress is a slot of DWELL+2 cycles;
  // m_pos is the cycle index inside it (0 = RAM read, 1 = data returns,
  // 2..DWELL+1 = shown).
  bit m_busy;
  int m_pos;
  int m_addr;
  int m_disp_addr;
  int m_disp_data;
  bit m_valid;
  bit m_frame;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit s, input bit rs);
    if (rs) begin
      m_busy = 0; m_pos = 0; m_addr = 0;
      m_disp_addr = 0; m_disp_data = 0; m_valid = 0; m_frame = 0;
    end else begin
      m_frame = 0;
      if (!m_busy) begin
        if (r || s) begin
          m_busy = 1;
          m_pos  = 0;
        end
      end else if (m_pos == 1) begin
        m_disp_addr = m_addr;
        m_disp_data = 'h10 + m_addr;
        m_valid     = 1;
        m_pos       = 2;
      end else if (m_pos == DWELL + 1) begin
        m_frame = (m_addr == DEPTH - 1);
        m_addr  = (m_addr + 1) % DEPTH;
        if (r) m_pos = 0;
        else   m_busy = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic check_output();
    check("ram_en",     32'(ram_bus.ram_en),   32'(m_busy && m_pos == 0));
    check("ram_addr",   32'(ram_bus.ram_addr), 32'(m_addr));
    check("disp_addr",  32'(disp_addr),        32'(m_disp_addr));
    check("disp_data",  32'(disp_data),        32'(m_disp_data));
    check("disp_valid", 32'(disp_valid),       32'(m_valid));
    check("frame_done", 32'(frame_done),       32'(m_frame));
  endtask

  // One clock: inputs change at the falling edge, the model advances on the
  // rising edge, outputs are compared at the next falling edge.
  task automatic apply_stimulus(input bit r, input bit s, input bit rs);
    run   = r;
    step  = s;
    reset = rs;
    @(posedge clk);
    model_update(r, s, rs);
    @(negedge clk);
    check_output();
  endtask

  initial begin
    int  frames;
    bit  run_mode;
    for (int i = 0; i < DEPTH; i++) image[i] = RAM_WIDTH'(8'h10 + i);
    run = 1'b1; step = 1'b0; reset = 1'b1;

    $display("[TB] reset held with run=1");
    apply_stimulus(1, 0, 1);
    apply_stimulus(1, 0, 1);
    check("rst_disp_data", 32'(disp_data), 32'h0);
    check("rst_disp_valid", 32'(disp_valid), 32'h0);

    $display("[TB] free run from idle");
    apply_stimulus(1, 0, 0);
    check("lat_ram_en", 32'(ram_bus.ram_en), 32'h1);
    apply_stimulus(1, 0, 0);
    check("lat_not_yet", 32'(disp_data), 32'h0);
    apply_stimulus(1, 0, 0);
    check("first_entry", 32'(disp_data), 32'h10);
    for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 0);
    check("second_entry", 32'(disp_data), 32'h11);

    $display("[TB] wrap over a full frame");
    frames = 0;
    for (int i = 0; i < DEPTH * (DWELL + 2); i++) begin
      apply_stimulus(1, 0, 0);
      if (frame_done === 1'b1) frames++;
    end
    check("frame_pulses", 32'(frames), 32'd1);
    for (int i = 0; i < DWELL + 2; i++) apply_stimulus(0, 0, 0);
    check("idle_after_run", 32'(ram_bus.ram_en), 32'h0);

    $display("[TB] single step");
    apply_stimulus(0, 0, 1);
    apply_stimulus(0, 1, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 1, 0);
    for (int i = 0; i < DWELL + 3; i++) apply_stimulus(0, 0, 0);
    check("step1_addr", 32'(disp_addr), 32'h0);
    check("step1_data", 32'(disp_data), 32'h10);
    apply_stimulus(0, 1, 0);
    for (int i = 0; i < DWELL + 3; i++) apply_stimulus(0, 0, 0);
    check("step2_addr", 32'(disp_addr), 32'h1);
    check("step2_data", 32'(disp_data), 32'h11);

    $display("[TB] run dropped mid-show");
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 0);
    check("mid_addr", 32'(disp_addr), 32'h2);
    for (int i = 0; i < DWELL + 4; i++) apply_stimulus(0, 0, 0);
    check("hold_data", 32'(disp_data), 32'h12);
    check("hold_en", 32'(ram_bus.ram_en), 32'h0);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0);
    check("resume_addr", 32'(disp_addr), 32'h3);
    for (int i = 0; i < DWELL + 1; i++) apply_stimulus(0, 0, 0);

    $display("[TB] reset during wait");
    apply_stimulus(1, 0, 0);
    apply_stimulus(1, 0, 0);
    apply_stimulus(1, 0, 1);
    check("wrst_data", 32'(disp_data), 32'h0);
    check("wrst_valid", 32'(disp_valid), 32'h0);
    check("wrst_addr", 32'(ram_bus.ram_addr), 32'h0);

    $display("[TB] randomized run/step/reset");
    run_mode = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) run_mode = ~run_mode;
      apply_stimulus(run_mode, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
